// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//
// Resolves conditional branches in the EX stage and registers the outcome
// into the EX/MEM boundary. A mispredict raises a one-cycle flush together
// with the correct next PC. Saturating counters track branches and
// mispredicts.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   stall              pipeline hold; freezes every register in this block
//   idex_valid         EX-stage instruction valid
//   idex_op            EX-stage opcode
//   idex_funct3        branch condition select
//   idex_pc            EX-stage PC
//   idex_imm           sign-extended B-type offset
//   rs1_val, rs2_val   forwarded source operands
//   idex_pred_taken    prediction made at fetch
//   exmem_op           registered opcode (0 = bubble)
//   exmem_taken        registered actual branch outcome
//   flush              registered one-cycle mispredict flush
//   redirect_pc        registered correct next PC, valid while flush=1
//   branch_cnt         saturating count of resolved branches
//   mispred_cnt        saturating count of mispredicted branches
//
// Flow control: there is no valid/ready handshake here. idex_valid only
// qualifies the EX slot; stall=1 freezes every register (outputs included)
// on that edge, and stall=0 lets the EX slot advance into EX/MEM.
// ---------------------------------------------------------------------------
module branch_resolver (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        idex_valid,
    input  logic [6:0]  idex_op,
    input  logic [2:0]  idex_funct3,
    input  logic [31:0] idex_pc,
    input  logic [31:0] idex_imm,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic        idex_pred_taken,
    output logic [6:0]  exmem_op,
    output logic        exmem_taken,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispred_cnt
);

    localparam logic [6:0]  OP_BRANCH = 7'b110_0011;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    logic [6:0]  exmem_op_q;
    logic        exmem_taken_q;
    logic        flush_q;
    logic [31:0] redirect_pc_q;
    logic [15:0] branch_cnt_q;
    logic [15:0] mispred_cnt_q;

    logic        is_branch;
    logic        taken;
    logic        mispredict;
    logic [31:0] target_pc;
    logic [31:0] fall_pc;

    // While flush is high the EX slot holds a wrong-path instruction, so it
    // is neither evaluated nor counted.
    assign is_branch  = idex_valid && (idex_op == OP_BRANCH) && !flush_q;
    assign mispredict = is_branch && (taken != idex_pred_taken);
    assign target_pc  = idex_pc + idex_imm;
    assign fall_pc    = idex_pc + 32'd4;

    always_comb begin
        taken = 1'b0;
        unique case (idex_funct3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val <  rs2_val);
            3'b111:  taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            exmem_op_q    <= 7'd0;
            exmem_taken_q <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'd0;
            branch_cnt_q  <= 16'd0;
            mispred_cnt_q <= 16'd0;
        end else if (!stall) begin
            exmem_op_q    <= (idex_valid && !flush_q) ? idex_op : 7'd0;
            exmem_taken_q <= is_branch && taken;
            // is_branch is gated by flush_q, so a flush can never repeat on
            // the following unstalled edge.
            flush_q       <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= taken ? target_pc : fall_pc;
            end
            if (is_branch && (branch_cnt_q != CNT_MAX)) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
                mispred_cnt_q <= mispred_cnt_q + 16'd1;
            end
        end
    end

    assign exmem_op    = exmem_op_q;
    assign exmem_taken = exmem_taken_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
